rs_dispatch_scheduler: RTL and testbench

RS_DISPATCH_SCHEDULER -- requirements
Module: rs_dispatch_scheduler

---
 rtl/rs_dispatch_scheduler_pkg.sv | 18 +
 rtl/rs_dispatch_scheduler_group.sv | 122 ++++++++++++
 rtl/rs_dispatch_scheduler.sv | 41 ++++
 tb/tb_rs_dispatch_scheduler.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/rs_dispatch_scheduler_pkg.sv
// Shared sizes and types for the reservation-station dispatch scheduler.
// Station groups: ALU stations take the low bits of the ready bus, SHIFT stations the next ones.
package rs_dispatch_scheduler_pkg;

  localparam int NUM_ALU_RS   = 4;
  localparam int NUM_SHIFT_RS = 2;
  localparam int NUM_RS       = NUM_ALU_RS + NUM_SHIFT_RS;
  localparam int ADDR_W       = $clog2(NUM_RS + 1);

  typedef enum logic [0:0] {FG_ALU, FG_SHIFT} functional_group_t;
  typedef enum logic [0:0] {DS_IDLE, DS_OFFER} dispatch_state_t;

  // Index width for a group of n stations; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rs_dispatch_scheduler_group.sv
// Round-robin arbiter plus the per-group IDLE/OFFER dispatch FSM.
// One rs_dispatch_group instance (with its own rr_arbiter) serves one functional group.
module rr_arbiter
  import rs_dispatch_scheduler_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  logic [IW-1:0] w_pos;

  // First set request at or after ptr_i, searching upward with wrap.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    w_pos   = '0;
    for (int k = 0; k < N; k++) begin
      w_pos = IW'((int'(ptr_i) + k) % N);
      if (!valid_o && req_i[w_pos]) begin
        valid_o = 1'b1;
        idx_o   = w_pos;
      end
    end
  end

endmodule

module rs_dispatch_group
  import rs_dispatch_scheduler_pkg::*;
#(
  parameter int N    = 4,
  parameter int BASE = 0,
  parameter int IW   = idx_width(N)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic [N-1:0]      ready_i,
  input  logic              fu_ready_i,
  output logic              valid_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [N-1:0]      ack_o
);

  dispatch_state_t r_state, w_state_next;
  logic [IW-1:0]   r_idx, w_idx_next;
  logic [IW-1:0]   r_ptr, w_ptr_next;
  logic [IW-1:0]   w_idx_wrap;
  logic [N-1:0]    w_onehot;
  logic [N-1:0]    w_arb_req;
  logic [IW-1:0]   w_arb_ptr;
  logic [IW-1:0]   w_arb_idx;
  logic            w_arb_valid;

  assign w_idx_wrap = (r_idx == IW'(N - 1)) ? '0 : r_idx + 1'b1;

  always_comb begin
    w_onehot        = '0;
    w_onehot[r_idx] = 1'b1;
  end

  // While offering, the arbiter looks ahead for the successor so a handshake
  // can reload the offer without a bubble.
  assign w_arb_req = (r_state == DS_OFFER) ? (ready_i & ~w_onehot) : ready_i;
  assign w_arb_ptr = (r_state == DS_OFFER) ? w_idx_wrap : r_ptr;

  rr_arbiter #(.N(N), .IW(IW)) u_arb (
    .req_i   (w_arb_req),
    .ptr_i   (w_arb_ptr),
    .idx_o   (w_arb_idx),
    .valid_o (w_arb_valid)
  );

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_ptr_next   = r_ptr;
    ack_o        = '0;
    case (r_state)
      DS_IDLE: begin
        if (!flush_i && w_arb_valid) begin
          w_state_next = DS_OFFER;
          w_idx_next   = w_arb_idx;
        end
      end
      DS_OFFER: begin
        if (flush_i) begin
          w_state_next = DS_IDLE;
        end else if (fu_ready_i) begin
          ack_o      = rst_i ? '0 : w_onehot;
          w_ptr_next = w_idx_wrap;
          if (w_arb_valid) w_idx_next = w_arb_idx;
          else             w_state_next = DS_IDLE;
        end else if (!ready_i[r_idx]) begin
          w_state_next = DS_IDLE;
        end
      end
      default: w_state_next = DS_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= DS_IDLE;
      r_idx   <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      r_ptr   <= w_ptr_next;
    end
  end

  assign valid_o = (r_state == DS_OFFER);
  assign addr_o  = valid_o ? ADDR_W'(BASE + int'(r_idx) + 1) : '0;

endmodule

// File: rtl/rs_dispatch_scheduler.sv
// Offers one ready reservation station per functional unit each cycle, round-robin within a group.
// Addresses are 1-based across the whole station array; 0 means no offer.
module rs_dispatch_scheduler
  import rs_dispatch_scheduler_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NUM_RS-1:0] ready_bus_i,
  input  logic              flush_i,
  input  logic              alu_fu_ready_i,
  input  logic              shift_fu_ready_i,
  output logic              alu_valid_o,
  output logic [ADDR_W-1:0] alu_addr_o,
  output logic              shift_valid_o,
  output logic [ADDR_W-1:0] shift_addr_o,
  output logic [NUM_RS-1:0] dispatch_ack_o
);

  rs_dispatch_group #(.N(NUM_ALU_RS), .BASE(0)) u_alu (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .flush_i    (flush_i),
    .ready_i    (ready_bus_i[NUM_ALU_RS-1:0]),
    .fu_ready_i (alu_fu_ready_i),
    .valid_o    (alu_valid_o),
    .addr_o     (alu_addr_o),
    .ack_o      (dispatch_ack_o[NUM_ALU_RS-1:0])
  );

  rs_dispatch_group #(.N(NUM_SHIFT_RS), .BASE(NUM_ALU_RS)) u_shift (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .flush_i    (flush_i),
    .ready_i    (ready_bus_i[NUM_RS-1:NUM_ALU_RS]),
    .fu_ready_i (shift_fu_ready_i),
    .valid_o    (shift_valid_o),
    .addr_o     (shift_addr_o),
    .ack_o      (dispatch_ack_o[NUM_RS-1:NUM_ALU_RS])
  );

endmodule

// File: tb/tb_rs_dispatch_scheduler.sv
// Directed scenarios plus a randomized run against a queue-free behavioural model of the scheduler.
module tb_rs_dispatch_scheduler;
  import rs_dispatch_scheduler_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       afu = 1'b0;
  logic       sfu = 1'b0;
  logic [5:0] ready = '0;
  logic       alu_valid_o, shift_valid_o;
  logic [2:0] alu_addr_o, shift_addr_o;
  logic [5:0] dispatch_ack_o;
  int         n_checks = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  rs_dispatch_scheduler dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .ready_bus_i      (ready),
    .flush_i          (flush),
    .alu_fu_ready_i   (afu),
    .shift_fu_ready_i (sfu),
    .alu_valid_o      (alu_valid_o),
    .alu_addr_o       (alu_addr_o),
    .shift_valid_o    (shift_valid_o),
    .shift_addr_o     (shift_addr_o),
    .dispatch_ack_o   (dispatch_ack_o)
  );

  // Drive one cycle of inputs just after a rising edge, return at the falling edge for sampling.
  task automatic tick(input logic [5:0] rdy, input logic af, input logic sf, input logic fl, input logic rs);
    @(posedge clk); #1;
    ready = rdy; afu = af; sfu = sf; flush = fl; rst = rs;
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      tick(6'b111111, 1'b1, 1'b1, 1'b0, 1'b1);
      n_checks++; if ({alu_valid_o, alu_addr_o} !== 4'b0) begin n_fail++; $display("FAIL reset_alu: got %b expected 0000", {alu_valid_o, alu_addr_o}); end
      n_checks++; if ({shift_valid_o, shift_addr_o} !== 4'b0) begin n_fail++; $display("FAIL reset_shift: got %b expected 0000", {shift_valid_o, shift_addr_o}); end
      n_checks++; if (dispatch_ack_o !== 6'b0) begin n_fail++; $display("FAIL reset_ack: got %b expected 000000", dispatch_ack_o); end
    end
  endtask

  task automatic test_single_offer();
    tick(6'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(6'b000010, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++; if (alu_valid_o !== 1'b0) begin n_fail++; $display("FAIL single_latency: got valid %b expected 0", alu_valid_o); end
    tick(6'b000010, 1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++; if ({alu_valid_o, alu_addr_o} !== {1'b1, 3'd2}) begin n_fail++; $display("FAIL single_offer: got %b/%0d expected 1/2", alu_valid_o, alu_addr_o); end
    n_checks++; if (dispatch_ack_o !== 6'b000010) begin n_fail++; $display("FAIL single_ack: got %b expected 000010", dispatch_ack_o); end
    tick(6'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++; if ({alu_valid_o, alu_addr_o} !== 4'b0) begin n_fail++; $display("FAIL single_idle: got %b/%0d expected 0/0", alu_valid_o, alu_addr_o); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] r = 4'b1111;
    tick(6'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick({2'b00, r}, 1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++; if ({alu_valid_o, dispatch_ack_o} !== 7'b0) begin n_fail++; $display("FAIL b2b_idle_fu_ignored: got %b/%b expected 0/000000", alu_valid_o, dispatch_ack_o); end
    for (int k = 0; k < 4; k++) begin
      tick({2'b00, r}, 1'b1, 1'b0, 1'b0, 1'b0);
      n_checks++; if ({alu_valid_o, alu_addr_o} !== {1'b1, 3'(k + 1)}) begin n_fail++; $display("FAIL b2b_addr: got %b/%0d expected 1/%0d", alu_valid_o, alu_addr_o, k + 1); end
      n_checks++; if (dispatch_ack_o !== 6'(1 << k)) begin n_fail++; $display("FAIL b2b_ack: got %b expected %b", dispatch_ack_o, 6'(1 << k)); end
      r[k] = 1'b0;
    end
    tick(6'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++; if ({alu_valid_o, alu_addr_o} !== 4'b0) begin n_fail++; $display("FAIL b2b_drain: got %b/%0d expected 0/0", alu_valid_o, alu_addr_o); end
  endtask

  task automatic test_wrap();
    tick(6'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(6'b001000, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(6'b001000, 1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++; if ({alu_addr_o, dispatch_ack_o} !== {3'd4, 6'b001000}) begin n_fail++; $display("FAIL wrap_grant4: got %0d/%b expected 4/001000", alu_addr_o, dispatch_ack_o); end
    tick(6'b001001, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(6'b001001, 1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++; if ({alu_addr_o, dispatch_ack_o} !== {3'd1, 6'b000001}) begin n_fail++; $display("FAIL wrap_first: got %0d/%b expected 1/000001", alu_addr_o, dispatch_ack_o); end
    tick(6'b001000, 1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++; if ({alu_addr_o, dispatch_ack_o} !== {3'd4, 6'b001000}) begin n_fail++; $display("FAIL wrap_second: got %0d/%b expected 4/001000", alu_addr_o, dispatch_ack_o); end
  endtask

  task automatic test_hold_withdraw();
    tick(6'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(6'b000100, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      tick(6'b000100, 1'b0, 1'b0, 1'b0, 1'b0);
      n_checks++; if ({alu_valid_o, alu_addr_o, dispatch_ack_o} !== {1'b1, 3'd3, 6'b0}) begin n_fail++; $display("FAIL hold: got %b/%0d/%b expected 1/3/000000", alu_valid_o, alu_addr_o, dispatch_ack_o); end
    end
    tick(6'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++; if ({alu_valid_o, alu_addr_o} !== {1'b1, 3'd3}) begin n_fail++; $display("FAIL withdraw_same_cycle: got %b/%0d expected 1/3", alu_valid_o, alu_addr_o); end
    tick(6'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++; if ({alu_valid_o, alu_addr_o} !== 4'b0) begin n_fail++; $display("FAIL withdraw: got %b/%0d expected 0/0", alu_valid_o, alu_addr_o); end
  endtask

  task automatic test_dual();
    tick(6'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(6'b010001, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(6'b010001, 1'b1, 1'b1, 1'b0, 1'b0);
    n_checks++; if ({alu_addr_o, shift_valid_o, shift_addr_o} !== {3'd1, 1'b1, 3'd5}) begin n_fail++; $display("FAIL dual_addr: got %0d/%b/%0d expected 1/1/5", alu_addr_o, shift_valid_o, shift_addr_o); end
    n_checks++; if (dispatch_ack_o !== 6'b010001) begin n_fail++; $display("FAIL dual_ack: got %b expected 010001", dispatch_ack_o); end
  endtask

  task automatic test_flush_reset();
    tick(6'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(6'b000001, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(6'b000001, 1'b1, 1'b0, 1'b1, 1'b0);
    n_checks++; if ({alu_valid_o, dispatch_ack_o} !== {1'b1, 6'b0}) begin n_fail++; $display("FAIL flush_ack: got %b/%b expected 1/000000", alu_valid_o, dispatch_ack_o); end
    tick(6'b000001, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++; if (alu_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_idle: got %b expected 0", alu_valid_o); end
    tick(6'b000001, 1'b1, 1'b0, 1'b0, 1'b1);
    n_checks++; if ({alu_valid_o, dispatch_ack_o} !== {1'b1, 6'b0}) begin n_fail++; $display("FAIL rst_ack: got %b/%b expected 1/000000", alu_valid_o, dispatch_ack_o); end
    tick(6'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++; if ({alu_valid_o, alu_addr_o} !== 4'b0) begin n_fail++; $display("FAIL rst_idle: got %b/%0d expected 0/0", alu_valid_o, alu_addr_o); end
  endtask

  // Next ready station in group g, starting at 'from' and wrapping, skipping 'excl'; -1 if none.
  function automatic int pick(input logic [5:0] rdy, input int g, input int from, input int excl);
    int n = (g == 0) ? NUM_ALU_RS : NUM_SHIFT_RS;
    int base = (g == 0) ? 0 : NUM_ALU_RS;
    int p;
    for (int k = 0; k < n; k++) begin
      p = (from + k) % n;
      if (p != excl && rdy[3'(base + p)]) return p;
    end
    return -1;
  endfunction

  task automatic test_random();
    int         off[2], idx[2], ptr[2];
    logic       exp_valid[2];
    logic [2:0] exp_addr[2];
    logic [5:0] exp_ack, rdy;
    logic       af, sf, fl, rs, fu;
    int         n, base, w;
    tick(6'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    rdy = '0;
    for (int g = 0; g < 2; g++) begin off[g] = 0; idx[g] = 0; ptr[g] = 0; end
    for (int cyc = 0; cyc < 400; cyc++) begin
      rdy = rdy ^ (6'($urandom) & 6'($urandom));
      af  = 1'($urandom_range(0, 1));
      sf  = 1'($urandom_range(0, 1));
      fl  = ($urandom_range(0, 19) == 0);
      rs  = ($urandom_range(0, 49) == 0);
      tick(rdy, af, sf, fl, rs);
      exp_ack = '0;
      for (int g = 0; g < 2; g++) begin
        base = (g == 0) ? 0 : NUM_ALU_RS;
        fu   = (g == 0) ? af : sf;
        exp_valid[g] = (off[g] != 0);
        exp_addr[g]  = (off[g] != 0) ? 3'(base + idx[g] + 1) : 3'd0;
        if (off[g] != 0 && fu && !fl && !rs) exp_ack[3'(base + idx[g])] = 1'b1;
      end
      n_checks++; if ({alu_valid_o, alu_addr_o} !== {exp_valid[0], exp_addr[0]}) begin n_fail++; $display("FAIL rand_alu cyc %0d: got %b/%0d expected %b/%0d", cyc, alu_valid_o, alu_addr_o, exp_valid[0], exp_addr[0]); end
      n_checks++; if ({shift_valid_o, shift_addr_o} !== {exp_valid[1], exp_addr[1]}) begin n_fail++; $display("FAIL rand_shift cyc %0d: got %b/%0d expected %b/%0d", cyc, shift_valid_o, shift_addr_o, exp_valid[1], exp_addr[1]); end
      n_checks++; if (dispatch_ack_o !== exp_ack) begin n_fail++; $display("FAIL rand_ack cyc %0d: got %b expected %b", cyc, dispatch_ack_o, exp_ack); end
      for (int g = 0; g < 2; g++) begin
        n    = (g == 0) ? NUM_ALU_RS : NUM_SHIFT_RS;
        base = (g == 0) ? 0 : NUM_ALU_RS;
        fu   = (g == 0) ? af : sf;
        if (rs) begin
          off[g] = 0; ptr[g] = 0;
        end else if (fl) begin
          off[g] = 0;
        end else if (off[g] != 0 && fu) begin
          ptr[g] = (idx[g] + 1) % n;
          w = pick(rdy, g, ptr[g], idx[g]);
          if (w >= 0) idx[g] = w;
          else        off[g] = 0;
        end else if (off[g] != 0 && !rdy[3'(base + idx[g])]) begin
          off[g] = 0;
        end else if (off[g] == 0) begin
          w = pick(rdy, g, ptr[g], -1);
          if (w >= 0) begin off[g] = 1; idx[g] = w; end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_offer();
    test_back_to_back();
    test_wrap();
    test_hold_withdraw();
    test_dual();
    test_flush_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
